// File: rtl/xor_occupancy_ram_if.sv
// Port bundle for the two toggle/read ports of the occupancy bitmap.
// Latency: reads are combinational; a toggle takes effect one clock edge after it is requested.
// Backpressure: none. Every toggle request is accepted, so the bundle has no ready signal.
//
// Signals:
//   toggle0/addr0 -> occupied0 : port 0 toggle request, address, occupancy readback
//   toggle1/addr1 -> occupied1 : port 1 toggle request, address, occupancy readback
// master drives the requests and addresses; slave (the bitmap) drives the occupancy bits.
interface xor_occupancy_ram_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  toggle0;
   logic [ADDR_WIDTH-1:0] addr0;
   logic                  occupied0;
   logic                  toggle1;
   logic [ADDR_WIDTH-1:0] addr1;
   logic                  occupied1;

   modport master (
      output toggle0, addr0, toggle1, addr1,
      input  occupied0, occupied1
   );

   modport slave (
      input  toggle0, addr0, toggle1, addr1,
      output occupied0, occupied1
   );
endinterface

// File: rtl/xor_occupancy_ram.sv
// DEPTH x 1-bit occupancy bitmap with two independent toggle/read ports.
// Latency: reads are combinational on the pre-edge state; a toggle is visible one cycle after it is requested.
// Backpressure: none. Every toggle is accepted, and toggles are ignored while reset is held.
//
// Ports:
//   clk  : single clock; all state updates happen on posedge
//   rst  : asynchronous, active-low; clears the whole bitmap immediately
//   bus  : slave side of xor_occupancy_ram_if (toggleN/addrN in, occupiedN out)
//
// Each port owns a single-writer bank. A bit's occupancy is the XOR of the two banks, so
// toggles from both ports to the same slot in the same cycle cancel each other out.
module xor_occupancy_ram #(
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   xor_occupancy_ram_if.slave bus
);

   // DEPTH extended by one bit so that the range check also works when DEPTH is a power of 2.
   localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DEPTH-1:0] r_bank0;
   logic [DEPTH-1:0] r_bank1;

   logic w_in_range0;
   logic w_in_range1;

   // An address past the end of a non-power-of-2 bitmap neither toggles nor reads back as set.
   assign w_in_range0 = ({1'b0, bus.addr0} < LP_DEPTH);
   assign w_in_range1 = ({1'b0, bus.addr1} < LP_DEPTH);

   // Bank 0 is written only by port 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bank0 <= '0;
      end else if (bus.toggle0 && w_in_range0) begin
         r_bank0[bus.addr0] <= ~r_bank0[bus.addr0];
      end
   end

   // Bank 1 is written only by port 1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bank1 <= '0;
      end else if (bus.toggle1 && w_in_range1) begin
         r_bank1[bus.addr1] <= ~r_bank1[bus.addr1];
      end
   end

   // Both ports read the same XOR view, so a toggle from either port is seen by both.
   assign bus.occupied0 = w_in_range0 & (r_bank0[bus.addr0] ^ r_bank1[bus.addr0]);
   assign bus.occupied1 = w_in_range1 & (r_bank0[bus.addr1] ^ r_bank1[bus.addr1]);

endmodule

// File: tb/tb_xor_occupancy_ram.sv
// Scoreboard bench for xor_occupancy_ram. The driver pushes the expected occupancy for each
// cycle from a plain bit-array model. The monitor pops each entry and compares it with the
// DUT outputs at the falling edge.
module tb_xor_occupancy_ram;
   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   logic clk;
   logic rst_n;
   logic chk_vld;

   xor_occupancy_ram_if #(.ADDR_WIDTH(AW)) bus_if ();

   xor_occupancy_ram #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: one occupancy bit per slot; every toggle flips it, whichever port issues it.
   bit          occ [DEPTH];
   logic [1:0]  exp_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;

   // Monitor: one expected entry per checked cycle, sampled mid-cycle.
   always @(negedge clk) begin
      logic [1:0] e;
      if (chk_vld) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
         end else begin
            e = exp_q.pop_front();
            n_tests++;
            if (bus_if.occupied0 !== e[0]) begin
               n_fail++;
               $display("FAIL occupied0 addr0=%0d rst=%b: got %b expected %b at %0t",
                        bus_if.addr0, rst_n, bus_if.occupied0, e[0], $time);
            end
            n_tests++;
            if (bus_if.occupied1 !== e[1]) begin
               n_fail++;
               $display("FAIL occupied1 addr1=%0d rst=%b: got %b expected %b at %0t",
                        bus_if.addr1, rst_n, bus_if.occupied1, e[1], $time);
            end
         end
      end
   end

   // One cycle of stimulus. Inputs change just after posedge; the check happens at the next
   // negedge, before any further edge. The reset change is therefore observed without a clock.
   task automatic cyc(input bit rv, input bit t0, input int a0, input bit t1, input int a1);
      @(posedge clk);
      #1;
      rst_n          = rv;
      bus_if.toggle0 = t0;
      bus_if.addr0   = AW'(a0);
      bus_if.toggle1 = t1;
      bus_if.addr1   = AW'(a1);
      if (!rv) begin
         foreach (occ[i]) occ[i] = 1'b0;
      end
      exp_q.push_back({occ[a1], occ[a0]});
      chk_vld = 1'b1;
      // Effect of the coming edge on the model.
      if (rv) begin
         if (t0) occ[a0] = ~occ[a0];
         if (t1) occ[a1] = ~occ[a1];
      end
   endtask

   function automatic int pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return DEPTH - 1;
      if (r == 1) return 0;
      return $urandom_range(1, 12);
   endfunction

   initial begin
      int a0;
      int a1;
      rst_n          = 1'b0;
      chk_vld        = 1'b0;
      bus_if.toggle0 = 1'b0;
      bus_if.addr0   = '0;
      bus_if.toggle1 = 1'b0;
      bus_if.addr1   = '0;
      foreach (occ[i]) occ[i] = 1'b0;

      // Toggles requested while reset is held must have no effect.
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, i, 1'b1, i + 100);

      // Reset released: scan the whole bitmap on both ports.
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, i, 1'b0, DEPTH - 1 - i);

      // Single toggle on port 0; the old value is seen in the request cycle, and both ports see the new value.
      cyc(1'b1, 1'b1, 5, 1'b0, 5);
      cyc(1'b1, 1'b0, 5, 1'b0, 5);
      // Port 1 toggles the same slot back to clear.
      cyc(1'b1, 1'b0, 5, 1'b1, 5);
      cyc(1'b1, 1'b0, 5, 1'b0, 5);

      // Same-address toggles cancel; different-address toggles both land.
      cyc(1'b1, 1'b1, 7, 1'b1, 7);
      cyc(1'b1, 1'b0, 7, 1'b0, 7);
      cyc(1'b1, 1'b1, 8, 1'b1, 9);
      cyc(1'b1, 1'b0, 8, 1'b0, 9);
      cyc(1'b1, 1'b0, 9, 1'b0, 8);

      // Back-to-back toggles at the top address; slot 0 must not alias.
      cyc(1'b1, 1'b1, DEPTH - 1, 1'b0, 0);
      cyc(1'b1, 1'b1, DEPTH - 1, 1'b0, 0);
      cyc(1'b1, 1'b1, DEPTH - 1, 1'b0, 0);
      cyc(1'b1, 1'b0, DEPTH - 1, 1'b0, 0);

      // Set 3, 100, 1023, then assert reset between edges with a toggle pending.
      cyc(1'b1, 1'b1, 3, 1'b1, 100);
      cyc(1'b1, 1'b0, 3, 1'b1, DEPTH - 1);
      cyc(1'b1, 1'b0, 100, 1'b0, DEPTH - 1);
      cyc(1'b1, 1'b0, 3, 1'b0, 100);
      cyc(1'b0, 1'b1, 3, 1'b1, DEPTH - 1);
      cyc(1'b1, 1'b0, 100, 1'b0, 3);
      cyc(1'b1, 1'b1, 3, 1'b0, 8);
      cyc(1'b1, 1'b0, 3, 1'b0, 3);

      // Random traffic over a small address pool to force collisions, with occasional reset pulses.
      for (int i = 0; i < 2000; i++) begin
         a0 = pick_addr();
         a1 = ($urandom_range(0, 3) == 0) ? a0 : pick_addr();
         cyc(($urandom_range(0, 299) != 0), 1'($urandom), a0, 1'($urandom), a1);
      end

      @(negedge clk);
      #1;
      chk_vld = 1'b0;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
